// File: rtl/tx_fifo_arbiter_pkg.sv
// tx_fifo_arbiter_pkg
//   Shared definitions for the TX FIFO write-port arbiter:
//   - default parameter values (requester count, byte width, length width)
//   - FSM state encoding (ST_IDLE, ST_XFER)
//   - ptr_width(): width of a round-robin pointer addressing n requesters
package tx_fifo_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_fifo_arbiter_if.sv
// tx_fifo_arbiter_if
//   Bundles the requester handshake and the FIFO write port of the arbiter.
//   Signals:
//     REQ        per-requester frame request level
//     REQ_LEN    per-requester frame length (slice i = requester i, 0 = 2**LEN_WIDTH)
//     REQ_DATA   per-requester current byte (slice i = requester i)
//     GNT        one-hot grant, held for the whole frame
//     DATA_ACK   per-requester byte-consumed pulse
//     FRAME_DONE per-requester pulse coincident with the last byte's DATA_ACK
//     FIFO_FULL  FIFO write-side full flag
//     WR_DATA    FIFO write data
//     WR_INC     FIFO write strobe
//     BUSY       high while a frame is being transferred
//   Modports:
//     slave  - arbiter view
//     master - requesters/FIFO view
interface tx_fifo_arbiter_if
  import tx_fifo_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
);

  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*LEN_WIDTH-1:0]  REQ_LEN;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            GNT;
  logic [NUM_REQ-1:0]            DATA_ACK;
  logic [NUM_REQ-1:0]            FRAME_DONE;
  logic                          FIFO_FULL;
  logic [DATA_WIDTH-1:0]         WR_DATA;
  logic                          WR_INC;
  logic                          BUSY;

  modport slave (
    input  REQ, REQ_LEN, REQ_DATA, FIFO_FULL,
    output GNT, DATA_ACK, FRAME_DONE, WR_DATA, WR_INC, BUSY
  );

  modport master (
    output REQ, REQ_LEN, REQ_DATA, FIFO_FULL,
    input  GNT, DATA_ACK, FRAME_DONE, WR_DATA, WR_INC, BUSY
  );

endinterface

// File: rtl/tx_fifo_arbiter_rr_pick.sv
// tx_fifo_arbiter_rr_pick
//   Combinational round-robin selector. Picks the first set bit of req_i
//   searching upward from ptr_i with wrap-around.
//   Ports:
//     req_i   request vector
//     ptr_i   search start position (must be < NUM_REQ)
//     pick_o  one-hot selected requester (zero when no request)
//     valid_o at least one request is set
module tx_fifo_arbiter_rr_pick
  import tx_fifo_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned PW      = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] back;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   lowest;

  // Rotate so that bit 0 is req_i[ptr_i], isolate the lowest set bit,
  // then rotate back. Doubling the vector turns the rotation into a shift.
  always_comb begin
    dbl    = {req_i, req_i};
    rot    = NUM_REQ'(dbl >> ptr_i);
    lowest = rot & (~rot + 1'b1);
    back   = {{NUM_REQ{1'b0}}, lowest} << ptr_i;
    pick_o = back[NUM_REQ-1:0] | back[2*NUM_REQ-1:NUM_REQ];
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter
//   Round-robin, frame-locked arbiter placing multi-byte frames from
//   NUM_REQ requesters onto the single write port of the TX async FIFO.
//   A grant is issued one cycle after REQ and held until the latched frame
//   length has been written; FIFO_FULL stalls the transfer byte by byte.
//   Ports:
//     CLK  REF_CLK domain clock
//     RST  asynchronous active-low reset
//     bus  tx_fifo_arbiter_if.slave: REQ/REQ_LEN/REQ_DATA/FIFO_FULL in,
//          GNT/DATA_ACK/FRAME_DONE/WR_DATA/WR_INC/BUSY out
module tx_fifo_arbiter
  import tx_fifo_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  tx_fifo_arbiter_if.slave      bus
);

  localparam int unsigned PW = ptr_width(NUM_REQ);
  localparam int unsigned CW = LEN_WIDTH + 1;   // holds 2**LEN_WIDTH

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [CW-1:0]      cnt_q;

  logic [NUM_REQ-1:0]    pick;
  logic                  pick_valid;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         nxt_ptr;
  logic [CW-1:0]         load_len;
  logic                  in_xfer;
  logic                  wr_inc;
  logic                  last_byte;

  tx_fifo_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .req_i   (bus.REQ),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  // Length comes from the requester being picked now; data and the
  // granted index come from the registered grant.
  always_comb begin
    len_sel  = '0;
    data_sel = '0;
    gnt_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        len_sel = bus.REQ_LEN[i*LEN_WIDTH +: LEN_WIDTH];
      end
      if (gnt_q[i]) begin
        data_sel = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_idx  = PW'(i);
      end
    end
  end

  always_comb begin
    if (32'(gnt_idx) == NUM_REQ - 1) begin
      nxt_ptr = '0;
    end else begin
      nxt_ptr = gnt_idx + 1'b1;
    end
  end

  // A zero length field means a full 2**LEN_WIDTH byte frame.
  assign load_len  = (len_sel == '0) ? CW'(1 << LEN_WIDTH) : {1'b0, len_sel};

  assign in_xfer   = (state_q == ST_XFER);
  assign wr_inc    = in_xfer && !bus.FIFO_FULL;
  assign last_byte = wr_inc && (cnt_q == CW'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick;
            cnt_q   <= load_len;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (wr_inc) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              gnt_q    <= '0;
              rr_ptr_q <= nxt_ptr;
              state_q  <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.GNT        = gnt_q;
  assign bus.BUSY       = in_xfer;
  assign bus.WR_INC     = wr_inc;
  assign bus.WR_DATA    = in_xfer ? data_sel : '0;
  assign bus.DATA_ACK   = wr_inc ? gnt_q : '0;
  assign bus.FRAME_DONE = last_byte ? gnt_q : '0;

endmodule

// File: doc/tx_fifo_arbiter.md
Name: tx_fifo_arbiter

Overview:
Arbitrates multi-byte response frames from several REF_CLK-domain requesters onto the single write port of the TX async FIFO. The requesters are the system controller, an error/status reporter and spares. A grant is round-robin and frame-locked: once granted, a requester owns the FIFO write port until its whole frame is written. FIFO_FULL back-pressure is honoured byte by byte, so no byte is ever dropped or duplicated.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width written to FIFO
LEN_WIDTH, 4, frame length field width; 0 encodes 2**LEN_WIDTH bytes

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous active-low reset
REQ  in  NUM_REQ  per-requester frame request level
REQ_LEN  in  NUM_REQ*LEN_WIDTH  frame length; slice i belongs to requester i
REQ_DATA  in  NUM_REQ*DATA_WIDTH  current byte of each requester
GNT  out  NUM_REQ  one-hot grant, held for the whole frame
DATA_ACK  out  NUM_REQ  one-cycle pulse: current byte consumed, present next byte next cycle
FRAME_DONE  out  NUM_REQ  one-cycle pulse with last byte's DATA_ACK
FIFO_FULL  in  1  FIFO write-side full flag
WR_DATA  out  DATA_WIDTH  FIFO write data
WR_INC  out  1  FIFO write strobe
BUSY  out  1  high while in XFER

Behaviour:
- Reset (RST=0, async): state=IDLE; rr_ptr=0; byte counter=0; GNT, DATA_ACK, FRAME_DONE, WR_INC, BUSY=0; WR_DATA=0.
- States: IDLE, XFER.
- IDLE:
  - If any REQ bit is set, pick the first set bit searching upward from rr_ptr with wrap.
  - Register the one-hot GNT and latch that requester's REQ_LEN into the counter (0 loads 2**LEN_WIDTH).
  - Go to XFER next cycle. REQ to GNT latency is 1 cycle.
- XFER:
  - WR_INC = ~FIFO_FULL (combinational from registered state and FIFO_FULL).
  - WR_DATA = REQ_DATA slice of the granted requester (combinational mux). It is 0 when not in XFER.
  - DATA_ACK[g] = WR_INC.
  - Each WR_INC decrements the counter.
  - When WR_INC fires with counter==1: pulse FRAME_DONE[g], set rr_ptr=(g+1) mod NUM_REQ, clear GNT, go to IDLE.
- One idle bubble cycle always separates back-to-back frames. Maximum throughput is len bytes per len+1 cycles.
- FIFO_FULL high in XFER: WR_INC=0, no ACK, counter holds, GNT holds. Resume on the first cycle FIFO_FULL is low.
- REQ deasserted mid-frame: ignored; the frame completes its latched length.
- REQ_LEN changing mid-frame: ignored; the length is latched only at grant.
- REQ held high after FRAME_DONE: treated as a new frame request and arbitrated normally. The requester must drop REQ on FRAME_DONE if it has no further frame.
- Simultaneous REQ in IDLE: round-robin order from rr_ptr. No requester waits more than NUM_REQ-1 frames.
- Reset mid-frame: the frame is abandoned and all outputs clear immediately. The requester sees GNT drop without FRAME_DONE.
- Invariants: GNT is one-hot or zero. DATA_ACK, FRAME_DONE and WR_INC are never high outside XFER.

Decomposition:
- Shared constants header/package: state encodings (ST_IDLE, ST_XFER) and the default widths.
- One sub-module, rr_pick: a combinational round-robin selector with inputs req vector and rr_ptr, and outputs one-hot pick plus valid.
- The top instantiates rr_pick and holds the FSM, counter, muxes and rr_ptr.

Test Plan:
- Single requester 1, REQ_LEN=3, data A1/A2/A3, FIFO_FULL=0 -> GNT=0010 one cycle after REQ; WR_INC high 3 cycles with WR_DATA A1,A2,A3; FRAME_DONE[1] with the third ACK; rr_ptr=2.
- REQ=1111 at once, each len=2, from reset -> grants in order 0,1,2,3, then 0 again; one bubble cycle between frames; 8 writes total.
- Requester 0 len=4, FIFO_FULL high for 3 cycles after the 2nd byte -> WR_INC=0 and the counter held during stall; 4 writes total, no duplicate byte; GNT stable throughout.
- REQ_LEN=0 -> exactly 16 writes, then FRAME_DONE.
- RST pulsed low after byte 2 of a 5-byte frame -> GNT, WR_INC and BUSY are 0 immediately; no FRAME_DONE; after release an idle REQ-free cycle produces no writes.
- Requester 2 drops REQ after byte 1 of len=3 -> bytes 2 and 3 still written; FRAME_DONE[2] pulses.
